// File: rtl/vga_char_pkg.sv
// Shared definitions for the character-buffer streamer.
//   state_t      : streamer FSM state encoding
//   DEF_COLS/ROWS: default text-mode geometry (80x60)
//   SRAM_AW      : character-buffer SRAM word address width
//   IDX_W        : character index width
//   get_byte     : pick one character out of a 32-bit SRAM word
package vga_char_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 60;
    localparam int SRAM_AW  = 11;
    localparam int IDX_W    = 13;

    // Byte 0 sits at the lowest character address, so it goes out first.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] sel);
        return w[8*sel +: 8];
    endfunction

endpackage

// File: rtl/char_buf_streamer.sv
// Streams a frame of character codes out of a 32-bit character-buffer SRAM.
// Each SRAM word holds four characters; one word is fetched, then its four
// bytes are emitted on a valid/ready stream, one per accepted beat.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   enable                : level, allows a new frame to start from IDLE
//   sram_address/_chipselect/_clken : SRAM read port (1-cycle read latency)
//   sram_readdata         : four characters, byte 0 = lowest address
//   stream_*              : character stream with SOP/EOP framing
module char_buf_streamer
    import vga_char_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int BASE_WORD = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [SRAM_AW-1:0] sram_address,
    output logic               sram_chipselect,
    output logic               sram_clken,
    input  logic [31:0]        sram_readdata,
    output logic [7:0]         stream_data,
    output logic               stream_startofpacket,
    output logic               stream_endofpacket,
    output logic               stream_valid,
    input  logic               stream_ready
);

    localparam int NCHARS = COLS * ROWS;
    localparam logic [IDX_W-1:0]   LAST      = IDX_W'(NCHARS - 1);
    localparam logic [SRAM_AW-1:0] BASE_ADDR = SRAM_AW'(BASE_WORD);

    generate
        if (COLS < 4 || (COLS % 4) != 0) begin : g_bad_cols
            $error("char_buf_streamer: COLS must be a multiple of 4 and at least 4");
        end
        if (NCHARS / 4 + BASE_WORD > (1 << SRAM_AW)) begin : g_bad_size
            $error("char_buf_streamer: frame does not fit the SRAM word address space");
        end
    endgenerate

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        word;
    logic [IDX_W-1:0]   idx_nxt;
    logic [SRAM_AW-1:0] fetch_addr_nxt;
    logic               xfer;

    assign idx_nxt        = idx + 1'b1;
    assign fetch_addr_nxt = BASE_ADDR + idx_nxt[IDX_W-1:2];
    assign xfer           = stream_valid && stream_ready;

    // All outputs are registered: stream_ready only steers next-state logic,
    // so there is no combinational path from ready to valid/data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            idx                  <= '0;
            word                 <= '0;
            sram_address         <= '0;
            sram_chipselect      <= 1'b0;
            sram_clken           <= 1'b0;
            stream_data          <= '0;
            stream_startofpacket <= 1'b0;
            stream_endofpacket   <= 1'b0;
            stream_valid         <= 1'b0;
        end else begin
            // Read strobes are single-cycle pulses that cover only FETCH;
            // the address register keeps its last value otherwise.
            sram_chipselect <= 1'b0;
            sram_clken      <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (enable) begin
                        state           <= S_FETCH;
                        sram_address    <= BASE_ADDR;
                        sram_chipselect <= 1'b1;
                        sram_clken      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid now; it also feeds the first beat
                    // directly so EMIT starts without a further cycle.
                    word                 <= sram_readdata;
                    stream_data          <= get_byte(sram_readdata, idx[1:0]);
                    stream_startofpacket <= (idx == '0);
                    stream_endofpacket   <= (idx == LAST);
                    stream_valid         <= 1'b1;
                    state                <= S_EMIT;
                end
                S_EMIT: begin
                    if (xfer) begin
                        stream_startofpacket <= 1'b0;
                        if (idx == LAST) begin
                            state              <= S_IDLE;
                            idx                <= '0;
                            stream_valid       <= 1'b0;
                            stream_endofpacket <= 1'b0;
                        end else if (idx[1:0] == 2'd3) begin
                            state              <= S_FETCH;
                            idx                <= idx_nxt;
                            stream_valid       <= 1'b0;
                            stream_endofpacket <= 1'b0;
                            sram_address       <= fetch_addr_nxt;
                            sram_chipselect    <= 1'b1;
                            sram_clken         <= 1'b1;
                        end else begin
                            idx                <= idx_nxt;
                            stream_data        <= get_byte(word, idx_nxt[1:0]);
                            stream_endofpacket <= (idx_nxt == LAST);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_buf_streamer.sv
module tb_char_buf_streamer;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        stream_ready = 1'b0;
    logic [10:0] sram_address, sram_address_b;
    logic        sram_chipselect, sram_chipselect_b;
    logic        sram_clken, sram_clken_b;
    logic [31:0] sram_readdata = '0, sram_readdata_b = '0;
    logic [7:0]  stream_data, stream_data_b;
    logic        stream_startofpacket, stream_startofpacket_b;
    logic        stream_endofpacket, stream_endofpacket_b;
    logic        stream_valid, stream_valid_b;

    logic [31:0] mem [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    beat_t       beats_q[$];
    int          beat_cyc_q[$];
    logic [10:0] addr_q[$];
    int          fetch_cyc_q[$];
    logic [10:0] addr_b_q[$];
    beat_t       tbl[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    char_buf_streamer #(.COLS(8), .ROWS(2), .BASE_WORD(0)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sram_address(sram_address), .sram_chipselect(sram_chipselect),
        .sram_clken(sram_clken), .sram_readdata(sram_readdata),
        .stream_data(stream_data), .stream_startofpacket(stream_startofpacket),
        .stream_endofpacket(stream_endofpacket), .stream_valid(stream_valid),
        .stream_ready(stream_ready));

    char_buf_streamer #(.COLS(8), .ROWS(2), .BASE_WORD(32'h100)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sram_address(sram_address_b), .sram_chipselect(sram_chipselect_b),
        .sram_clken(sram_clken_b), .sram_readdata(sram_readdata_b),
        .stream_data(stream_data_b), .stream_startofpacket(stream_startofpacket_b),
        .stream_endofpacket(stream_endofpacket_b), .stream_valid(stream_valid_b),
        .stream_ready(stream_ready));

    // SRAM models: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (sram_clken && sram_chipselect) sram_readdata <= mem[sram_address[1:0]];
        if (sram_clken_b && sram_chipselect_b) sram_readdata_b <= mem[sram_address_b[1:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: logs beats and fetches, checks hold-during-stall rules.
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {stream_valid, stream_startofpacket, stream_endofpacket, stream_data},
                      {1'b1, prev_beat.sop, prev_beat.eop, prev_beat.data});
            if (stream_valid)
                check("no_read_while_valid", {sram_chipselect, sram_clken}, 0);
            if (sram_chipselect) begin
                addr_q.push_back(sram_address);
                fetch_cyc_q.push_back(cyc);
            end
            if (sram_chipselect_b) addr_b_q.push_back(sram_address_b);
            if (stream_valid && stream_ready) begin
                beats_q.push_back('{stream_data, stream_startofpacket, stream_endofpacket});
                beat_cyc_q.push_back(cyc);
            end
            prev_stall = stream_valid && !stream_ready;
            prev_beat  = '{stream_data, stream_startofpacket, stream_endofpacket};
        end
    end

    task automatic clear_logs();
        beats_q.delete(); beat_cyc_q.delete();
        addr_q.delete(); fetch_cyc_q.delete(); addr_b_q.delete();
    endtask

    task automatic pulse_enable();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
    endtask

    // mode 0: ready=1, mode 1: 1-0-0-1 pattern, mode 2: random
    task automatic run_until(input int n, input int budget, input int mode, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (beats_q.size() >= n) return;
            case (mode)
                0:       stream_ready = 1'b1;
                1:       stream_ready = (i % 4 == 0) || (i % 4 == 3);
                default: stream_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
        check({name, "_timeout"}, beats_q.size(), n);
    endtask

    task automatic check_frame(input string name, input int base);
        for (int k = 0; k < 16; k++) begin
            if (base + k < beats_q.size())
                check($sformatf("%s_beat%0d", name, k),
                      {beats_q[base+k].sop, beats_q[base+k].eop, beats_q[base+k].data},
                      {tbl[k].sop, tbl[k].eop, tbl[k].data});
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {stream_valid, stream_startofpacket, stream_endofpacket, stream_data,
                     sram_chipselect, sram_clken, sram_address}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t exp_q[$];
        for (int i = 0; i < 16; i++) tbl[i] = '{8'(i), (i == 0), (i == 15)};
        mem[0] = 32'h03020100; mem[1] = 32'h07060504;
        mem[2] = 32'h0B0A0908; mem[3] = 32'h0F0E0D0C;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk); #3 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_enable_valid", {stream_valid, sram_chipselect}, 0);

        // Basic frame, ready=1, one-cycle enable pulse
        clear_logs();
        pulse_enable();
        run_until(16, 200, 0, "basic");
        check_frame("basic", 0);
        if (fetch_cyc_q.size() > 0 && beat_cyc_q.size() >= 16)
            check("basic_24_cycles", beat_cyc_q[15] - fetch_cyc_q[0], 23);
        repeat (40) @(posedge clk);
        #1;
        check("single_frame_beats", beats_q.size(), 16);
        check("single_frame_idle", stream_valid, 0);
        check("fetch_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < addr_q.size()) check($sformatf("fetch_addr%0d", i), addr_q[i], i);
        if (addr_b_q.size() >= 4) begin
            check("base_first_addr", addr_b_q[0], 32'h100);
            check("base_fourth_addr", addr_b_q[3], 32'h103);
        end else check("base_fetch_count", addr_b_q.size(), 4);
        check("addr_held_after_frame", sram_address, 3);

        // Backpressure 1-0-0-1
        clear_logs();
        pulse_enable();
        run_until(16, 400, 1, "stall");
        check_frame("stall", 0);
        stream_ready = 1'b1;
        repeat (20) @(posedge clk);

        // Enable held: back-to-back frames
        clear_logs();
        @(posedge clk); #1 enable = 1'b1;
        run_until(32, 400, 0, "b2b");
        enable = 1'b0;
        check_frame("b2b_f0", 0);
        check_frame("b2b_f1", 16);
        if (beat_cyc_q.size() >= 17)
            check("b2b_gap", beat_cyc_q[16] - beat_cyc_q[15], 4);
        repeat (40) @(posedge clk);
        #1 check("b2b_no_extra", beats_q.size(), 32);

        // Reset mid-frame at beat 6
        clear_logs();
        pulse_enable();
        run_until(6, 200, 0, "rst_pre");
        reset_n = 1'b0;
        #1 check_outputs_zero("midframe_reset_outputs");
        @(posedge clk); #3 reset_n = 1'b1;
        clear_logs();
        pulse_enable();
        run_until(16, 200, 0, "rst_post");
        check_frame("rst_post", 0);
        repeat (10) @(posedge clk);

        // Randomised frames against a byte-queue reference model
        for (int f = 0; f < 6; f++) begin
            for (int w = 0; w < 4; w++) mem[w] = $urandom;
            exp_q.delete();
            for (int k = 0; k < 16; k++)
                exp_q.push_back('{8'(mem[k/4] >> (8*(k%4))), (k == 0), (k == 15)});
            clear_logs();
            pulse_enable();
            run_until(16, 600, 2, "rand");
            for (int k = 0; k < 16; k++)
                if (k < beats_q.size())
                    check($sformatf("rand_f%0d_b%0d", f, k),
                          {beats_q[k].sop, beats_q[k].eop, beats_q[k].data},
                          {exp_q[k].sop, exp_q[k].eop, exp_q[k].data});
            stream_ready = 1'b1;
            repeat (12) @(posedge clk);
            #1 check($sformatf("rand_f%0d_count", f), beats_q.size(), 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
